// File: rtl/rr_sel_arbiter8_pkg.sv
// rtl/rr_sel_arbiter8_pkg.sv - shared state encodings, sizes and helpers for the round-robin select arbiter
package rr_sel_arbiter8_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter8_pick8.sv
// rtl/rr_sel_arbiter8_pick8.sv - combinational round-robin pick: rotate, fixed-priority encode, add back
module rr_pick8
  import rr_sel_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             win_valid_o
);

  logic [IDX_W-1:0]   start;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  // rot[j] is requester (start + j) mod 8, so the lowest set bit is the next in turn
  always_comb begin
    start = last_i + 3'd1;
    dbl   = {req_i, req_i} >> start;
    rot   = dbl[N_REQ-1:0];
    off   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = IDX_W'(j);
    end
  end

  assign win_idx_o   = start + off;
  assign win_valid_o = |req_i;

endmodule

// File: rtl/rr_sel_arbiter8.sv
// rtl/rr_sel_arbiter8.sv - round-robin owner arbiter driving the one-hot grant and mux8_1 select code
module rr_sel_arbiter8
  import rr_sel_arbiter8_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CW       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             release_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] sel_o,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam logic [CW-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CW'(HOLD_MAX - 1);
  localparam logic [CW-1:0] HOLD_SAT  = {CW{1'b1}};

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CW-1:0]    hold_q, hold_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] pick_last;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             owner_req;
  logic             exit_hold;
  logic             exit_any;

  // While owning, the owner becomes the pointer so it is searched last on re-arbitration
  assign pick_last = (state_q == OWN) ? sel_q : last_q;

  rr_pick8 u_pick (
    .req_i       (req_i),
    .last_i      (pick_last),
    .win_idx_o   (win_idx),
    .win_valid_o (win_valid)
  );

  assign owner_req = req_i[sel_q];
  assign exit_hold = (HOLD_MAX != 0) && (hold_q == HOLD_LAST);
  assign exit_any  = !owner_req || release_i || exit_hold;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = OWN;
          grant_d = onehot8(win_idx);
          sel_d   = win_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      OWN: begin
        if (exit_any) begin
          last_d    = sel_q;
          timeout_d = exit_hold && owner_req && !release_i;
          hold_d    = '0;
          if (win_valid) begin
            grant_d = onehot8(win_idx);
            sel_d   = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= 3'd7;
      hold_q    <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign sel_o     = sel_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_sel_arbiter8.sv
// tb/tb_rr_sel_arbiter8.sv - directed and random checks of rr_sel_arbiter8 against a reference model
module tb_rr_sel_arbiter8;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] req_i;
  logic       release_i;
  logic [7:0] grant_o;
  logic [2:0] sel_o;
  logic       busy_o;
  logic       timeout_o;

  always #5 clk = ~clk;

  rr_sel_arbiter8 #(.HOLD_MAX(HM), .CW(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .release_i (release_i),
    .grant_o   (grant_o),
    .sel_o     (sel_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  bit         m_own;
  int         m_owner, m_last, m_hold;
  logic [7:0] m_grant;
  logic [2:0] m_sel;
  logic       m_busy, m_to;

  function automatic int ref_pick(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] r, input logic rel, input logic rs);
    int  w;
    bit  ea, eb, ec;
    m_to = 1'b0;
    if (rs) begin
      m_own = 0; m_owner = 0; m_last = 7; m_hold = 0;
      m_grant = 8'h00; m_sel = 3'd0; m_busy = 1'b0;
    end else if (!m_own) begin
      w = ref_pick(r, m_last);
      if (w >= 0) begin
        m_own = 1; m_owner = w; m_hold = 0;
        m_grant = 8'h01 << w; m_sel = 3'(w); m_busy = 1'b1;
      end
    end else begin
      ea = !r[m_owner];
      eb = rel;
      ec = (HM != 0) && (m_hold == HM - 1);
      if (ea || eb || ec) begin
        m_to   = ec && !ea && !eb;
        m_last = m_owner;
        w      = ref_pick(r, m_owner);
        if (w >= 0) begin
          m_owner = w; m_hold = 0;
          m_grant = 8'h01 << w; m_sel = 3'(w);
        end else begin
          m_own = 0; m_grant = 8'h00; m_busy = 1'b0;
        end
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [7:0] r, input logic rel, input logic rs, input string tag);
    obs_t e;
    req_i     = r;
    release_i = rel;
    rst_i     = rs;
    model_step(r, rel, rs);
    exp_q.push_back('{m_grant, m_sel, m_busy, m_to});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".grant"},   32'(grant_o),   32'(e.grant));
    check({tag, ".sel"},     32'(sel_o),     32'(e.sel));
    check({tag, ".busy"},    32'(busy_o),    32'(e.busy));
    check({tag, ".timeout"}, 32'(timeout_o), 32'(e.timeout));
    check({tag, ".onehot0"}, 32'($onehot0(grant_o)), 32'(1));
    check({tag, ".busy_or"}, 32'(busy_o),    32'(|grant_o));
  endtask

  initial begin
    rst_i = 1'b1; req_i = 8'h00; release_i = 1'b0;
    apply(8'h00, 1'b0, 1'b1, "reset");
    apply(8'hFF, 1'b1, 1'b1, "reset_ovr");
    check("reset.grant", 32'(grant_o), 32'h0);

    apply(8'h01, 1'b0, 1'b0, "t1_req");
    check("t1.grant", 32'(grant_o), 32'h01);
    apply(8'h00, 1'b0, 1'b0, "t1_drop");
    check("t1.sel_hold", 32'(sel_o), 32'd0);
    apply(8'h00, 1'b0, 1'b0, "t1_idle");

    apply(8'h00, 1'b0, 1'b1, "t2_rst");
    apply(8'hFF, 1'b0, 1'b0, "t2_first");
    for (int i = 0; i < 16; i++) apply(8'hFF, 1'(i % 2), 1'b0, "t2_rot");
    check("t2.wrap_grant", 32'(grant_o), 32'h01);
    apply(8'h00, 1'b0, 1'b0, "t2_drop");

    apply(8'h00, 1'b0, 1'b1, "t3_rst");
    apply(8'h24, 1'b0, 1'b0, "t3_first");
    for (int i = 0; i < 3; i++) apply(8'h24, 1'b0, 1'b0, "t3_hold2");
    apply(8'h24, 1'b0, 1'b0, "t3_to5");
    check("t3.grant5", 32'(grant_o), 32'h20);
    check("t3.timeout5", 32'(timeout_o), 32'd1);
    for (int i = 0; i < 3; i++) apply(8'h24, 1'b0, 1'b0, "t3_hold5");
    apply(8'h24, 1'b0, 1'b0, "t3_to2");
    check("t3.grant2", 32'(grant_o), 32'h04);

    apply(8'h00, 1'b0, 1'b1, "t4_rst");
    for (int i = 0; i < 12; i++) apply(8'h80, 1'b0, 1'b0, "t4_sole");
    check("t4.grant", 32'(grant_o), 32'h80);
    check("t4.sel", 32'(sel_o), 32'd7);

    apply(8'h00, 1'b0, 1'b1, "t5_rst");
    apply(8'h08, 1'b0, 1'b0, "t5_own3");
    check("t5.own3", 32'(grant_o), 32'h08);
    apply(8'hFF, 1'b0, 1'b1, "t5_midrst");
    check("t5.rst_sel", 32'(sel_o), 32'd0);
    apply(8'hFF, 1'b0, 1'b0, "t5_after");
    check("t5.first0", 32'(grant_o), 32'h01);

    apply(8'h00, 1'b0, 1'b1, "t6_rst");
    apply(8'h11, 1'b0, 1'b0, "t6_own0");
    for (int i = 0; i < 3; i++) apply(8'h11, 1'b0, 1'b0, "t6_hold");
    apply(8'h11, 1'b1, 1'b0, "t6_rel_to");
    check("t6.next4", 32'(grant_o), 32'h10);
    check("t6.no_to", 32'(timeout_o), 32'd0);
    apply(8'h00, 1'b0, 1'b0, "t6_idle");
    apply(8'h00, 1'b1, 1'b0, "t6_rel_idle");
    check("t6.idle_sel", 32'(sel_o), 32'd4);
    check("t6.idle_busy", 32'(busy_o), 32'd0);

    for (int i = 0; i < 80; i++) begin
      apply(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
